data_sampling_mv: RTL and testbench
===================================

Name: data_sampling_mv

Overview:
Parametrised successor of the UART RX bit sampler. It takes a programmable odd number of samples (1/3/5/7) of rx_in in a window centred on the mid-bit edge count and resolves them by strict majority vote. It also reports non-unanimous (noisy) bits and invalid window configurations. It sits between the RX edge/bit counter and the deserializer/start/parity/stop checkers, and is driven by the oversampling clock.

Parameters:
EDGE_W, 6, width of edge_cnt.
PRESC_W, 6, width of prescale.
MAX_SAMPLES, 5, largest supported vote size; odd, 1..7. Selecting a larger mode raises cfg_err.

Ports:
clk  input  1  oversampling clock (prescale x baud)
reset  input  1  asynchronous, active-high reset
dat_samp_en  input  1  sampling enable from RX FSM
edge_cnt  input  EDGE_W  edge position within current bit, 0..prescale-1, +1 per clk
prescale  input  PRESC_W  oversampling ratio (e.g. 8, 16, 32)
samp_mode  input  2  vote size: 0=1, 1=3, 2=5, 3=7 samples
rx_in  input  1  serial line, already synchronised
sampled_bit  output  1  voted bit value
sample_valid  output  1  one-cycle pulse: sampled_bit updated
noise_flag  output  1  last voted bit was not unanimous
cfg_err  output  1  current prescale/samp_mode window is invalid

Behaviour:
- Reset (async, reset=1): sampled_bit=0, sample_valid=0, noise_flag=0, cfg_err=0; vote counters cleared; latched mode = 0.
- Derived values: N = 2*samp_mode+1, h = samp_mode, c = prescale>>1 (floor). Window is edge_cnt in [c-h, c+h].
- Window valid iff c >= h AND c+h <= prescale-1 AND N <= MAX_SAMPLES. All arithmetic is unsigned, at least PRESC_W+1 bits wide, so there is no wrap-around.
- cfg_err is a registered output, recomputed every clk while dat_samp_en=1. While the window is invalid: no samples are taken, sample_valid stays 0, counters are held at 0.
- samp_mode is latched at the first window point (edge_cnt==c-h). A mode change mid-window has no effect until the next bit.
- Sample qualification: a sample is taken only if edge_cnt is in the window AND differs from the previous cycle's edge_cnt (or this is the first enabled cycle). A stalled edge_cnt therefore never double-counts.
- Counters: sample_cnt and ones_cnt, 3 bits each. Both are cleared at the first window point, and that point's sample is loaded (ones_cnt = rx_in).
- At the last window point (edge_cnt==c+h):
  - total = ones_cnt + rx_in.
  - Next cycle: sampled_bit = (total > h); noise_flag = (total != 0 AND total != N); sample_valid = 1 for exactly one cycle.
  - Counters clear.
- Latency: sample_valid rises one clk after the cycle in which edge_cnt==c+h was presented.
- Mode 0 (N=1): a single sample at edge_cnt==c. Valid pulses the next cycle; noise_flag is always 0.
- sampled_bit and noise_flag hold their values between valid pulses.
- dat_samp_en=0: counters cleared, sample_valid=0, noise_flag=0, cfg_err=0, sampled_bit=0. A partial window is discarded with no pulse.
- Enable asserted mid-window (after c-h): the bit is not voted; no pulse until the next full window.
- At most one sample_valid pulse per bit period.

Test Plan:
- prescale=8, samp_mode=1, rx_in=1 at edge 3, 0 at edge 4, 1 at edge 5 -> samples at edges 3,4,5; sampled_bit=1, noise_flag=1, sample_valid high the cycle after edge 5 only.
- prescale=16, samp_mode=2, rx_in=0 throughout edges 6..10 -> sampled_bit=0, noise_flag=0, exactly one valid pulse per 16 clks over 10 consecutive bits.
- prescale=4, samp_mode=2 -> window 0..4 exceeds 3, so cfg_err=1 and no sample_valid. Switch to samp_mode=1 -> cfg_err=0 and valid pulses resume.
- MAX_SAMPLES=5, samp_mode=3, prescale=16 -> cfg_err=1. samp_mode=0 with rx_in=1 at edge 8 -> sampled_bit=1 one clk after edge 8.
- prescale=8, samp_mode=1: deassert dat_samp_en at edge 4, reassert at edge 5 -> no pulse for that bit; the next bit votes normally. Hold edge_cnt=4 for 3 clks with rx_in=0 -> counted once.
- reset=1 asserted mid-window at edge 4 -> all outputs 0 immediately (async). After release, first valid pulse follows the next complete window.

Source files
------------

// File: rtl/data_sampling_mv.sv
// Majority-vote RX bit sampler: takes 1/3/5/7 samples centred on the mid-bit edge count,
// votes them, and flags noisy bits and invalid sampling windows.
module data_sampling_mv #(
    parameter int unsigned EDGE_W      = 6,
    parameter int unsigned PRESC_W     = 6,
    parameter int unsigned MAX_SAMPLES = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dat_samp_en,
    input  logic [EDGE_W-1:0]  edge_cnt,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [1:0]         samp_mode,
    input  logic               rx_in,
    output logic               sampled_bit,
    output logic               sample_valid,
    output logic               noise_flag,
    output logic               cfg_err
);

    // One bit wider than either operand so window bounds never wrap.
    localparam int unsigned AW = ((PRESC_W > EDGE_W) ? PRESC_W : EDGE_W) + 1;

    typedef logic [AW-1:0] arith_t;

    typedef enum logic [0:0] {
        StIdle,
        StVote
    } state_e;

    function automatic logic win_ok(input arith_t pre, input logic [1:0] mode);
        arith_t ctr;
        arith_t h;
        ctr = pre >> 1;
        h   = arith_t'(mode);
        return (ctr >= h) && ((ctr + h + arith_t'(1)) <= pre) &&
               (32'({mode, 1'b1}) <= MAX_SAMPLES);
    endfunction

    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [2:0] sample_cnt_q, sample_cnt_d;
    logic [2:0] ones_cnt_q, ones_cnt_d;
    logic       sampled_bit_q, sampled_bit_d;
    logic       valid_q, valid_d;
    logic       noise_q, noise_d;
    logic       cfg_err_q, cfg_err_d;
    logic [EDGE_W-1:0] prev_edge_q;
    logic       prev_en_q;

    arith_t pre_w;
    arith_t ctr;
    arith_t edge_w;
    arith_t lo_cur;
    arith_t lo_lat;
    arith_t hi_lat;
    logic   ok_cur;
    logic   ok_lat;
    logic   fresh;

    logic [3:0] total;
    logic       finish;
    logic [1:0] fin_mode;
    logic [2:0] fin_cnt;

    assign pre_w  = arith_t'(prescale);
    assign ctr    = pre_w >> 1;
    assign edge_w = arith_t'(edge_cnt);
    assign lo_cur = ctr - arith_t'(samp_mode);
    assign lo_lat = ctr - arith_t'(mode_q);
    assign hi_lat = ctr + arith_t'(mode_q);
    assign ok_cur = win_ok(pre_w, samp_mode);
    assign ok_lat = win_ok(pre_w, mode_q);

    // A stalled edge counter must not be sampled twice.
    assign fresh = !prev_en_q || (edge_cnt != prev_edge_q);

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        sample_cnt_d  = sample_cnt_q;
        ones_cnt_d    = ones_cnt_q;
        sampled_bit_d = sampled_bit_q;
        noise_d       = noise_q;
        valid_d       = 1'b0;
        cfg_err_d     = 1'b0;
        total         = 4'd0;
        finish        = 1'b0;
        fin_mode      = mode_q;
        fin_cnt       = 3'd0;

        if (!dat_samp_en) begin
            state_d       = StIdle;
            sample_cnt_d  = 3'd0;
            ones_cnt_d    = 3'd0;
            sampled_bit_d = 1'b0;
            noise_d       = 1'b0;
        end else begin
            cfg_err_d = !ok_cur;
            unique case (state_q)
                StIdle: begin
                    sample_cnt_d = 3'd0;
                    ones_cnt_d   = 3'd0;
                    if (ok_cur && fresh && (edge_w == lo_cur)) begin
                        mode_d = samp_mode;
                        if (samp_mode == 2'd0) begin
                            finish   = 1'b1;
                            fin_mode = 2'd0;
                            fin_cnt  = 3'd1;
                            total    = {3'b000, rx_in};
                        end else begin
                            sample_cnt_d = 3'd1;
                            ones_cnt_d   = {2'b00, rx_in};
                            state_d      = StVote;
                        end
                    end
                end
                StVote: begin
                    if (!ok_lat) begin
                        state_d      = StIdle;
                        sample_cnt_d = 3'd0;
                        ones_cnt_d   = 3'd0;
                    end else if (fresh) begin
                        if ((edge_w < lo_lat) || (edge_w > hi_lat)) begin
                            state_d      = StIdle;
                            sample_cnt_d = 3'd0;
                            ones_cnt_d   = 3'd0;
                        end else if (edge_w == hi_lat) begin
                            finish       = 1'b1;
                            fin_mode     = mode_q;
                            fin_cnt      = sample_cnt_q + 3'd1;
                            total        = {1'b0, ones_cnt_q} + {3'b000, rx_in};
                            state_d      = StIdle;
                            sample_cnt_d = 3'd0;
                            ones_cnt_d   = 3'd0;
                        end else begin
                            sample_cnt_d = sample_cnt_q + 3'd1;
                            ones_cnt_d   = ones_cnt_q + {2'b00, rx_in};
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            // Only a window that saw every one of its N samples produces a vote.
            if (finish && (fin_cnt == {fin_mode, 1'b1})) begin
                valid_d       = 1'b1;
                sampled_bit_d = total > {2'b00, fin_mode};
                noise_d       = (total != 4'd0) && (total != {1'b0, fin_mode, 1'b1});
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            mode_q        <= 2'd0;
            sample_cnt_q  <= 3'd0;
            ones_cnt_q    <= 3'd0;
            sampled_bit_q <= 1'b0;
            valid_q       <= 1'b0;
            noise_q       <= 1'b0;
            cfg_err_q     <= 1'b0;
            prev_edge_q   <= '0;
            prev_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            sample_cnt_q  <= sample_cnt_d;
            ones_cnt_q    <= ones_cnt_d;
            sampled_bit_q <= sampled_bit_d;
            valid_q       <= valid_d;
            noise_q       <= noise_d;
            cfg_err_q     <= cfg_err_d;
            prev_edge_q   <= edge_cnt;
            prev_en_q     <= dat_samp_en;
        end
    end

    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = valid_q;
    assign noise_flag   = noise_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_data_sampling_mv.sv
// Directed bench for data_sampling_mv: a table of whole-bit frames plus hand-written
// sequences for mode latching, enable drop, stalled edge count and mid-window reset.
module tb_data_sampling_mv;

    logic       clk;
    logic       reset;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [5:0] prescale;
    logic [1:0] samp_mode;
    logic       rx_in;
    logic       sampled_bit;
    logic       sample_valid;
    logic       noise_flag;
    logic       cfg_err;

    int   total;
    int   bad;
    int   n_pulse;
    logic got_bit;
    logic got_noise;

    typedef struct {
        int          p;
        logic [1:0]  m;
        logic [31:0] pat;
        int          pulses;
        logic        bitv;
        logic        noise;
        logic        err;
    } vec_t;

    vec_t vecs[18];

    data_sampling_mv #(
        .EDGE_W     (6),
        .PRESC_W    (6),
        .MAX_SAMPLES(5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .prescale    (prescale),
        .samp_mode   (samp_mode),
        .rx_in       (rx_in),
        .sampled_bit (sampled_bit),
        .sample_valid(sample_valid),
        .noise_flag  (noise_flag),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (sample_valid === 1'b1) begin
            n_pulse++;
            got_bit   = sampled_bit;
            got_noise = noise_flag;
        end
    endtask

    task automatic drive(input int e, input logic r);
        edge_cnt = 6'(e);
        rx_in    = r;
        step();
    endtask

    task automatic run_frame(input int p, input logic [1:0] m, input logic [31:0] pat);
        prescale  = 6'(p);
        samp_mode = m;
        for (int e = 0; e < p; e++) drive(e, pat[e]);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_pulse = 0;
        got_bit = 1'bx;
        got_noise = 1'bx;

        //          p   mode   rx pattern  pulses bit   noise cfg_err
        vecs[0]  = '{8,  2'd1, 32'h28,     1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{8,  2'd1, 32'hFF,     1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8,  2'd1, 32'h10,     1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{16, 2'd2, 32'h0,      1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16, 2'd2, 32'h1C0,    1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{16, 2'd2, 32'hC0,     1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{16, 2'd2, 32'hFFFF,   1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{4,  2'd2, 32'hF,      0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{4,  2'd1, 32'hE,      1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16, 2'd3, 32'hFFFF,   0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{16, 2'd0, 32'h100,    1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{16, 2'd0, 32'hFEFF,   1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32, 2'd2, 32'h54000,  1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{8,  2'd2, 32'h7C,     1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{8,  2'd3, 32'hFF,     0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{2,  2'd0, 32'h2,      1, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{16, 2'd1, 32'h280,    1, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{8,  2'd0, 32'h10,     1, 1'b1, 1'b0, 1'b0};

        reset       = 1'b1;
        dat_samp_en = 1'b0;
        edge_cnt    = 6'd0;
        prescale    = 6'd8;
        samp_mode   = 2'd1;
        rx_in       = 1'b0;
        #3;
        check("reset sampled_bit", 32'(sampled_bit), 32'd0);
        check("reset sample_valid", 32'(sample_valid), 32'd0);
        check("reset noise_flag", 32'(noise_flag), 32'd0);
        check("reset cfg_err", 32'(cfg_err), 32'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        dat_samp_en = 1'b1;

        for (int i = 0; i < 18; i++) begin
            n_pulse   = 0;
            got_bit   = 1'bx;
            got_noise = 1'bx;
            run_frame(vecs[i].p, vecs[i].m, vecs[i].pat);
            check($sformatf("row%0d pulses", i), 32'(n_pulse), 32'(vecs[i].pulses));
            if (vecs[i].pulses > 0) begin
                check($sformatf("row%0d sampled_bit", i), 32'(got_bit), 32'(vecs[i].bitv));
                check($sformatf("row%0d noise_flag", i), 32'(got_noise), 32'(vecs[i].noise));
            end
            check($sformatf("row%0d cfg_err", i), 32'(cfg_err), 32'(vecs[i].err));
        end

        // Ten back-to-back quiet bits: one pulse each.
        for (int b = 0; b < 10; b++) begin
            n_pulse = 0;
            got_bit = 1'bx;
            run_frame(16, 2'd2, 32'h0);
            check($sformatf("train%0d pulses", b), 32'(n_pulse), 32'd1);
            check($sformatf("train%0d sampled_bit", b), 32'(got_bit), 32'd0);
        end

        // Mode switched to 0 after the window opened: the 3-sample vote still completes.
        n_pulse   = 0;
        got_noise = 1'bx;
        prescale  = 6'd8;
        samp_mode = 2'd1;
        for (int e = 0; e < 4; e++) drive(e, 1'b0);
        samp_mode = 2'd0;
        drive(4, 1'b1);
        drive(5, 1'b1);
        drive(6, 1'b0);
        drive(7, 1'b0);
        check("latch pulses", 32'(n_pulse), 32'd1);
        check("latch sampled_bit", 32'(got_bit), 32'd1);
        check("latch noise_flag", 32'(got_noise), 32'd1);
        check("latch cfg_err", 32'(cfg_err), 32'd0);

        // Enable dropped for one edge mid-window.
        n_pulse   = 0;
        samp_mode = 2'd1;
        for (int e = 0; e < 4; e++) drive(e, 1'b1);
        dat_samp_en = 1'b0;
        drive(4, 1'b1);
        check("disable sampled_bit", 32'(sampled_bit), 32'd0);
        check("disable noise_flag", 32'(noise_flag), 32'd0);
        dat_samp_en = 1'b1;
        for (int e = 5; e < 8; e++) drive(e, 1'b1);
        check("disable pulses", 32'(n_pulse), 32'd0);
        n_pulse = 0;
        got_bit = 1'bx;
        run_frame(8, 2'd1, 32'hFF);
        check("reenable pulses", 32'(n_pulse), 32'd1);
        check("reenable sampled_bit", 32'(got_bit), 32'd1);

        // Edge count stalls at 4 for three clocks.
        n_pulse = 0;
        got_bit = 1'bx;
        got_noise = 1'bx;
        for (int e = 0; e < 3; e++) drive(e, 1'b0);
        drive(3, 1'b1);
        drive(4, 1'b0);
        drive(4, 1'b0);
        drive(4, 1'b0);
        drive(5, 1'b1);
        drive(6, 1'b0);
        drive(7, 1'b0);
        check("stall pulses", 32'(n_pulse), 32'd1);
        check("stall sampled_bit", 32'(got_bit), 32'd1);
        check("stall noise_flag", 32'(got_noise), 32'd1);

        // Asynchronous reset in the middle of a window.
        n_pulse = 0;
        for (int e = 0; e < 5; e++) drive(e, 1'b1);
        reset = 1'b1;
        #2;
        check("async sampled_bit", 32'(sampled_bit), 32'd0);
        check("async noise_flag", 32'(noise_flag), 32'd0);
        check("async sample_valid", 32'(sample_valid), 32'd0);
        step();
        reset = 1'b0;
        for (int e = 5; e < 8; e++) drive(e, 1'b1);
        check("post-reset partial pulses", 32'(n_pulse), 32'd0);
        n_pulse   = 0;
        got_bit   = 1'bx;
        got_noise = 1'bx;
        run_frame(8, 2'd1, 32'h38);
        check("post-reset pulses", 32'(n_pulse), 32'd1);
        check("post-reset sampled_bit", 32'(got_bit), 32'd1);
        check("post-reset noise_flag", 32'(got_noise), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
